// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory request/response port, the redirect input
// and the decode-side valid/ready port of the fetch stage.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests,
// buffers in-order responses in a small FIFO and flushes on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic          req_s, grant_s, rsp_s, push_s, valid_s, pop_s;
    logic [CW:0]   credit_s;
    logic [31:0]   redir_pc_s;

    // A request is only raised while in-flight plus buffered entries leave room,
    // so every accepted response is guaranteed a FIFO slot.
    assign credit_s   = {1'b0, outst_q} + {1'b0, count_q};
    assign req_s      = !reset && !bus.redirect && (credit_s < DEPTH_W);
    assign grant_s    = req_s && bus.imem_gnt;
    assign rsp_s      = bus.imem_rvalid && (outst_q != '0);
    assign push_s     = rsp_s && !bus.redirect && (discard_q == '0);
    assign valid_s    = !reset && !bus.redirect && (count_q != '0);
    assign pop_s      = valid_s && bus.id_ready;
    assign redir_pc_s = {bus.redirect_pc[31:2], 2'b00};

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.id_valid  = valid_s;
    assign bus.id_instr  = instr_mem_q[rd_ptr_q];
    assign bus.id_pc     = pc_mem_q[rd_ptr_q];

    // Next-state for PCs, credit counters and FIFO pointers.
    always_comb begin
        outst_d = outst_q + CW'(grant_s) - CW'(rsp_s);
        if (bus.redirect) begin
            fetch_pc_d = redir_pc_s;
            resp_pc_d  = redir_pc_s;
            discard_d  = outst_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            fetch_pc_d = grant_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
            resp_pc_d  = push_s ? (resp_pc_q + 32'd4) : resp_pc_q;
            discard_d  = discard_q - CW'(rsp_s && (discard_q != '0));
            count_d    = count_q + CW'(push_s) - CW'(pop_s);
            rd_ptr_d   = rd_ptr_q + AW'(pop_s);
            wr_ptr_d   = wr_ptr_q + AW'(push_s);
        end
    end

    // State registers and FIFO storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]    <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push_s) begin
                instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
                pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            end else begin
                instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
                pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model plus a queue-based
// reference of the expected instruction stream, credit and redirect behaviour.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clk = 1'b0;
    logic reset;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          gcyc;
    } req_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          was_rst = 1'b0;
    int          gnt_mode, ready_mode, rv_mode;
    bit          obs_valid;
    logic [31:0] m_fpc, m_rpc;
    int          m_disc;
    req_t        mq[$];
    logic [31:0] fq[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return ($urandom_range(1, 0) == 1);
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit spur);
        bit          rv_real, exp_req, exp_valid, g, rdy;
        int          osz;
        logic [31:0] tgt;
        osz = mq.size();
        reset           = rst;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        rv_real = 1'b0;
        if (!rst && osz > 0 && mq[0].gcyc < cyc && pick(rv_mode)) begin
            rv_real         = 1'b1;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memf(mq[0].addr);
            void'(mq.pop_front());
        end else if (!rst && spur && osz == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = $urandom;
        end
        #1;
        exp_req   = !rst && !redir && (osz + fq.size() < DEPTH);
        exp_valid = !rst && !redir && (fq.size() > 0);
        chk("req", 32'(bus.imem_req), 32'(exp_req));
        if (!rst || was_rst) begin
            chk("addr", bus.imem_addr, m_fpc);
            chk("valid", 32'(bus.id_valid), 32'(exp_valid));
        end
        if (rst && was_rst) begin
            chk("rst_instr", bus.id_instr, 32'h0000_0000);
            chk("rst_pc", bus.id_pc, 32'h0000_0000);
        end
        if (exp_valid) begin
            chk("id_pc", bus.id_pc, fq[0]);
            chk("id_instr", bus.id_instr, memf(fq[0]));
        end
        g   = pick(gnt_mode);
        rdy = pick(ready_mode);
        bus.imem_gnt = g;
        bus.id_ready = rdy;
        obs_valid    = bus.id_valid;
        if (rst) begin
            mq.delete();
            fq.delete();
            m_fpc  = RESET_PC;
            m_rpc  = RESET_PC;
            m_disc = 0;
        end else begin
            if (exp_valid && rdy) void'(fq.pop_front());
            if (rv_real && !redir) begin
                if (m_disc > 0) m_disc--;
                else begin
                    fq.push_back(m_rpc);
                    m_rpc = m_rpc + 32'd4;
                end
            end
            if (exp_req && g) begin
                mq.push_back('{m_fpc, cyc});
                m_fpc = m_fpc + 32'd4;
            end
            if (redir) begin
                tgt    = {rpc[31:2], 2'b00};
                m_fpc  = tgt;
                m_rpc  = tgt;
                fq.delete();
                m_disc = mq.size();
            end
        end
        was_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        gnt_mode = 0; rv_mode = 1; ready_mode = 1;
        for (int i = 0; i < 20 && (mq.size() > 0 || fq.size() > 0); i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_bound", 32'(mq.size() + fq.size()), 32'd0);
    endtask

    initial begin
        int first_v;
        reset = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;
        m_fpc = RESET_PC; m_rpc = RESET_PC; m_disc = 0;
        gnt_mode = 1; rv_mode = 1; ready_mode = 1;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

        // streaming with single-cycle memory; id_valid rises two cycles after reset
        first_v = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (first_v < 0 && obs_valid) first_v = i;
        end
        chk("latency", 32'(first_v), 32'd2);

        ready_mode = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        ready_mode = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        gnt_mode = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        gnt_mode = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // redirect with two requests in flight and responses held back
        drain();
        gnt_mode = 1; rv_mode = 0; ready_mode = 1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        rv_mode = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // redirect coinciding with a response, unaligned target
        step(1'b0, 1'b1, 32'h0000_0203, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0080, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // spurious response with nothing outstanding must be ignored
        drain();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("spurious_idle", 32'(obs_valid), 32'd0);

        // PC wrap at the top of the address space
        gnt_mode = 1; rv_mode = 1; ready_mode = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            bit          r, rd, sp;
            logic [31:0] t;
            if (i % 50 == 0) begin
                gnt_mode   = $urandom_range(2, 1);
                rv_mode    = $urandom_range(2, 1);
                ready_mode = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(2, 1);
            end
            r  = ($urandom_range(299, 0) == 0);
            rd = ($urandom_range(15, 0) == 0);
            sp = ($urandom_range(19, 0) == 0);
            t  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F)) : $urandom;
            step(r, rd, t, sp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
